instr_prefetch: RTL

Instruction fetch stage for the ARM core, directly upstream of the instruction decoder. It issues word fetches to instruction memory over a request/response handshake and buffers returned words with their PCs in a small in-order queue. It presents the head instruction, plus the Op/Funct/Rd slices the decoder consumes, under a valid/ready handshake. It flushes and refetches on a taken-branch or PC-write redirect.

---
 rtl/instr_prefetch.sv | 121 ++++++++++++
 1 files changed

// File: rtl/instr_prefetch.sv
// Instruction fetch stage: in-order fetch queue with credit-based issue and redirect flush.
// Optional same-cycle response bypass to the decoder is enabled by defining IFETCH_BYPASS_EN.
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic [1:0]  Op,
    output logic [5:0]  Funct,
    output logic [3:0]  Rd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc, resp_pc;
    logic [CW-1:0] count, outstanding, discard;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];

    logic [CW:0]   inflight;
    logic          accept, rsp, keep, bypass, head_vld, pop, push;
    logic [31:0]   redir_aligned;

    // Issue credit: queued words plus in-flight fetches never exceed DEPTH
    assign inflight      = {1'b0, count} + {1'b0, outstanding};
    assign imem_req      = !reset && !redirect && (inflight < (CW+1)'(DEPTH));
    assign imem_addr     = fetch_pc;
    assign accept        = imem_req && imem_ready;
    assign redir_aligned = {redirect_pc[31:2], 2'b00};

    // Responses with nothing outstanding are protocol errors and are ignored
    assign rsp  = imem_rvalid && (outstanding != '0);
    assign keep = rsp && (discard == '0) && !redirect;

`ifdef IFETCH_BYPASS_EN
    assign bypass = keep && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign head_vld    = (count != '0);
    assign instr_valid = head_vld || bypass;
    assign pop         = head_vld && instr_ready && !redirect;
    assign push        = keep && !(bypass && instr_ready);

    always_comb begin
        PC    = 32'h0;
        Instr = 32'h0;
        if (bypass) begin
            PC    = resp_pc;
            Instr = imem_rdata;
        end else if (head_vld) begin
            PC    = q_pc[rd_ptr];
            Instr = q_instr[rd_ptr];
        end
    end

    assign PCPlus8 = PC + 32'd8;
    assign Op      = Instr[27:26];
    assign Funct   = Instr[25:20];
    assign Rd      = Instr[15:12];

    // Control state: pointers, counters, fetch/response PCs
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect) begin
            // Everything still in flight after this cycle's response is stale
            fetch_pc    <= redir_aligned;
            resp_pc     <= redir_aligned;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= outstanding - CW'(rsp);
            discard     <= outstanding - CW'(rsp);
        end else begin
            if (accept)
                fetch_pc <= fetch_pc + 32'd4;
            if (keep)
                resp_pc <= resp_pc + 32'd4;
            outstanding <= outstanding + CW'(accept) - CW'(rsp);
            if (rsp && (discard != '0))
                discard <= discard - CW'(1);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage carries no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= resp_pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule
